// File: rtl/riscv_fetch_if.sv
// Fetch unit bus bundle: imem request/response channel, redirect input and decode-side output.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface riscv_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/riscv_fetch.sv
// RISC-V instruction fetch: credit-limited word requests, in-order response FIFO, redirect with kill of stale responses.
// Optional RISCV_FETCH_PERF_EN adds a saturating decode-bubble counter port.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef RISCV_FETCH_PERF_EN
  output logic [31:0] bubble_count,
`endif
  riscv_fetch_if.master bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] kill;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] pcq_wr;
  logic [PTR_W-1:0] pcq_rd;
  logic [PTR_W-1:0] fifo_wr;
  logic [PTR_W-1:0] fifo_rd;
  logic [31:0]      pcq       [BUF_DEPTH];
  logic [31:0]      fifo_data [BUF_DEPTH];
  logic [31:0]      fifo_pc   [BUF_DEPTH];

  logic             credit;
  logic             accept;
  logic             resp;
  logic             drop;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding_nxt;

  assign bus.inst_valid    = (fifo_count != '0);
  assign bus.inst          = bus.inst_valid ? fifo_data[fifo_rd] : '0;
  assign bus.inst_pc       = bus.inst_valid ? fifo_pc[fifo_rd] : '0;
  assign bus.imem_req_addr = fetch_pc;

  // Buffered plus in-flight words never exceed the FIFO size, so a response always has a slot.
  always_comb begin
    credit             = ({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT_MAX;
    bus.imem_req_valid = !reset && !bus.redirect_valid && credit;
    accept             = bus.imem_req_valid && bus.imem_req_ready;
    resp               = bus.imem_resp_valid;
    drop               = resp && ((kill != '0) || bus.redirect_valid);
    push               = resp && !drop;
    pop                = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    outstanding_nxt    = outstanding + CNT_W'(accept) - CNT_W'(resp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      // A redirect condemns every request still in flight, including ones already being killed.
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        kill     <= outstanding_nxt;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp && (kill != '0)) begin
          kill <= kill - CNT_W'(1);
        end
      end

      if (accept) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= pcq_wr + PTR_W'(1);
      end
      if (resp) begin
        pcq_rd <= pcq_rd + PTR_W'(1);
      end

      if (bus.redirect_valid) begin
        fifo_rd    <= fifo_wr;
        fifo_count <= '0;
      end else begin
        if (push) begin
          fifo_data[fifo_wr] <= bus.imem_resp_data;
          fifo_pc[fifo_wr]   <= pcq[pcq_rd];
          fifo_wr            <= fifo_wr + PTR_W'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + PTR_W'(1);
        end
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef RISCV_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (bus.inst_ready && !bus.inst_valid && (bubble_count != 32'hFFFF_FFFF)) begin
      bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Scoreboard bench for riscv_fetch: driver queues expected requests/instructions, a negedge monitor checks them.
// Memory model answers accepted requests in order from a queue, optionally held back to create in-flight requests.
module tb_riscv_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  riscv_fetch_if bus();
`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] bubble_count;
`endif

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [31:0] mem_q[$];
  logic [31:0] exp_req[$];
  logic [63:0] exp_inst[$];
  bit          acc_flag;
  int          acc_total;

  riscv_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef RISCV_FETCH_PERF_EN
    .bubble_count (bubble_count),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_compared++;
    if (act !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic void expect_fetch(input logic [31:0] pc);
    exp_req.push_back(pc);
    exp_inst.push_back({mem_word(pc), pc});
  endfunction

  // One cycle: drive inputs at negedge, then record whether memory accepted a request.
  task automatic applyStimulus(input bit rst, input bit rdy, input bit ird, input bit rdv,
                               input logic [31:0] rpc, input bit resp_en);
    @(negedge clk);
    reset              = rst;
    bus.imem_req_ready = rdy;
    bus.inst_ready     = ird;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = rpc;
    if (rst) begin
      mem_q.delete();
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end else if (resp_en && mem_q.size() > 0) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mem_q.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
    #1;
    acc_flag = !rst && bus.imem_req_valid && rdy;
    if (acc_flag) mem_q.push_back(bus.imem_req_addr);
  endtask

  task automatic run_until_accepts(input int n);
    int got = 0;
    for (int c = 0; c < 50 && got < n; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      if (acc_flag) got++;
    end
    checkOutput("accept_budget", 32'(got), 32'(n));
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  // Monitor: every accepted request and every consumed instruction is matched against the queues.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
      if (exp_req.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL req_unexpected: got addr %h, expected no request", bus.imem_req_addr);
      end else begin
        checkOutput("req_addr", bus.imem_req_addr, exp_req.pop_front());
      end
    end
    if (!reset && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
      if (exp_inst.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL inst_unexpected: got pc %h inst %h, expected none", bus.inst_pc, bus.inst);
      end else begin
        logic [63:0] e;
        e = exp_inst.pop_front();
        checkOutput("inst_pc", bus.inst_pc, e[31:0]);
        checkOutput("inst_word", bus.inst, e[63:32]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset               = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b0;

    // Reset, then sequential streaming from RESET_PC.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("req_valid_in_reset", 32'(bus.imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("rst_inst", bus.inst, 32'h0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);
    checkOutput("rst_req_addr", bus.imem_req_addr, RST_PC);
    checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    for (int i = 0; i < 6; i++) expect_fetch(RST_PC + 32'(4 * i));
    run_until_accepts(6);

    // Decode stalled: only BUF_DEPTH requests go out, head holds steady.
    expect_fetch(32'h118);
    expect_fetch(32'h11C);
    acc_total = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (acc_flag) acc_total++;
    end
    checkOutput("stall_requests", 32'(acc_total), 32'd2);
    checkOutput("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
    checkOutput("stall_head_pc", bus.inst_pc, 32'h118);
    checkOutput("stall_head_inst", bus.inst, mem_word(32'h118));
    expect_fetch(32'h120);
    expect_fetch(32'h124);
    run_until_accepts(2);

    // Redirect with two requests in flight: both responses dropped.
    exp_req.push_back(32'h128);
    exp_req.push_back(32'h12C);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h2002, 1'b0);
    checkOutput("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
    expect_fetch(32'h2000);
    expect_fetch(32'h2004);
    run_until_accepts(2);

    // Redirect coinciding with a response and inst_ready: no stale pop, response dropped.
    exp_req.push_back(32'h2008);
    exp_req.push_back(32'h200C);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h3000, 1'b1);
    checkOutput("redir2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    expect_fetch(32'h3000);
    expect_fetch(32'h3004);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("flush_inst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("redir2_req_addr", bus.imem_req_addr, 32'h3000);
    run_until_accepts(1);

    // PC wraps from the top of the address space to zero.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    expect_fetch(32'hFFFF_FFF8);
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0000_0000);
    run_until_accepts(3);

    // Reset mid-stream with two requests outstanding; memory is reset too.
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("mid_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("mid_rst_req_addr", bus.imem_req_addr, RST_PC);
    checkOutput("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("mid_rst_inst_pc", bus.inst_pc, 32'h0);
`ifdef RISCV_FETCH_PERF_EN
    checkOutput("bubble_after_reset", bubble_count, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef RISCV_FETCH_PERF_EN
    checkOutput("bubble_one", bubble_count, 32'd1);
`endif
    expect_fetch(RST_PC);
    expect_fetch(RST_PC + 32'd4);
    run_until_accepts(2);

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("req_left", 32'(exp_req.size()), 32'd0);
    checkOutput("inst_left", 32'(exp_inst.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
